// File: rtl/aud_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aud_pkg
// Description : Shared types and constants for the playback sample source.
//               Holds the playback-mode and control-state encodings, the
//               reciprocal table used by the interpolator and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package aud_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int RECIP_W    = 17;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    FAST      = 2'd1,
    SLOW_HOLD = 2'd2,
    SLOW_LIN  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // ceil(65536 / s) for s = 1..8, indexed by the speed code (s - 1).
  // Rounding up keeps the interpolation weight exact at multiples of 1/s.
  localparam logic [RECIP_W-1:0] C_RECIP [8] = '{
    17'd65536, 17'd32768, 17'd21846, 17'd16384,
    17'd13108, 17'd10923, 17'd9363,  17'd8192
  };

endpackage
`default_nettype wire

// File: rtl/aud_dsp_lerp.sv
`default_nettype none
// ============================================================================
// Module      : aud_lerp
// Description : Combinational linear interpolation between two samples.
//               o_sample = prev + floor((cur - prev) * cnt * R[s] / 65536)
// Ports       : i_prev   - older sample (signed)
//               i_cur    - newer sample (signed)
//               i_cnt    - position within the slow-motion hold, 0..s-1
//               i_speed  - speed code, s = i_speed + 1
//               o_sample - interpolated sample (signed)
// Revision    : 1.0 - initial release
// ============================================================================
module aud_lerp
  import aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] i_prev,
  input  logic signed [DATA_W-1:0] i_cur,
  input  logic        [2:0]        i_cnt,
  input  logic        [2:0]        i_speed,
  output logic signed [DATA_W-1:0] o_sample
);

  localparam int WEIGHT_W = RECIP_W + 3;
  // Wide enough that diff * cnt * R never wraps, whatever cnt and s are.
  localparam int PROD_W   = DATA_W + 1 + WEIGHT_W + 1;

  logic signed [DATA_W:0]     diff;
  logic        [WEIGHT_W-1:0] weight;
  logic signed [PROD_W-1:0]   prod;

  always_comb begin
    diff     = (DATA_W+1)'(i_cur) - (DATA_W+1)'(i_prev);
    weight   = WEIGHT_W'(i_cnt) * WEIGHT_W'(C_RECIP[i_speed]);
    prod     = PROD_W'(diff) * $signed(PROD_W'(weight));
    // Arithmetic shift floors toward -inf; the step is strictly smaller
    // in magnitude than diff, so the sum stays between prev and cur.
    o_sample = i_prev + DATA_W'(prod >>> 16);
  end

endmodule
`default_nettype wire

// File: rtl/aud_dsp.sv
`default_nettype none
// ============================================================================
// Module      : aud_dsp
// Description : Playback sample source. Walks the SRAM and presents one
//               sample per DACLRCK frame in normal, fast, slow-hold or
//               slow-linear mode, under start/pause/stop control.
// Ports       : i_clk, i_rst_n      - BCLK, async active-low reset
//               i_start/i_pause/i_stop - level control requests
//               i_mode, i_speed     - playback mode, speed code (s = speed+1)
//               i_daclrck           - frame clock (synchronous to i_clk)
//               i_end_addr          - last valid sample address
//               i_sram_data         - SRAM read data
//               o_sram_addr         - SRAM read address
//               o_dac_data          - sample for the player
//               o_player_en         - high while playing
//               o_done              - one-cycle end-of-data pulse
// Revision    : 1.0 - initial release
// ============================================================================
module aud_dsp
  import aud_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [2:0]        i_speed,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_player_en,
  output logic              o_done
);

  state_t                   state_q, state_d;
  mode_t                    mode_q,  mode_d;
  logic [2:0]               speed_q, speed_d;
  logic [ADDR_W:0]          addr_q,  addr_d;   // extra bit catches overrun
  logic [2:0]               cnt_q,   cnt_d;
  logic signed [DATA_W-1:0] prev_q,  prev_d;
  logic signed [DATA_W-1:0] cur_q,   cur_d;
  logic [DATA_W-1:0]        dac_q,   dac_d;
  logic                     done_q,  done_d;
  logic                     lrck_q;

  logic                     tick;
  logic                     slow_latched;
  logic                     load_tick;
  logic                     at_end;
  logic                     do_load;
  mode_t                    mode_n;
  logic [2:0]               speed_n;
  logic signed [DATA_W-1:0] prev_n;
  logic signed [DATA_W-1:0] cur_n;
  logic signed [DATA_W-1:0] lerp_sample;
  logic [ADDR_W:0]          addr_step;

  // Load path: what prev/cur/mode/speed become on this tick. Kept apart
  // from the FSM so the interpolator sees post-load values without a loop.
  always_comb begin
    tick         = i_daclrck & ~lrck_q;
    slow_latched = (mode_q == SLOW_HOLD) || (mode_q == SLOW_LIN);
    load_tick    = (state_q == PLAY) && !i_stop && !i_pause && tick &&
                   (!slow_latched || (cnt_q == 3'd0));
    at_end       = addr_q > {1'b0, i_end_addr};
    do_load      = load_tick && !at_end;
    mode_n       = do_load ? mode_t'(i_mode) : mode_q;
    speed_n      = do_load ? i_speed : speed_q;
    prev_n       = do_load ? cur_q : prev_q;
    cur_n        = do_load ? $signed(i_sram_data) : cur_q;
    addr_step    = (mode_n == FAST) ? (ADDR_W+1)'(speed_n) + (ADDR_W+1)'(1)
                                    : (ADDR_W+1)'(1);
  end

  aud_lerp #(
    .DATA_W (DATA_W)
  ) u_lerp (
    .i_prev   (prev_n),
    .i_cur    (cur_n),
    .i_cnt    (cnt_q),
    .i_speed  (speed_n),
    .o_sample (lerp_sample)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    dac_d   = dac_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!i_stop && !i_pause && i_start) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (i_stop) begin
          state_d = IDLE;
          addr_d  = '0;
          cnt_d   = '0;
          prev_d  = '0;
          cur_d   = '0;
          dac_d   = '0;
        end else if (i_pause) begin
          state_d = PAUSE;
          dac_d   = '0;
        end else if (load_tick && at_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          addr_d  = '0;
          dac_d   = '0;
        end else if (tick) begin
          mode_d  = mode_n;
          speed_d = speed_n;
          prev_d  = prev_n;
          cur_d   = cur_n;
          if (do_load) begin
            addr_d = addr_q + addr_step;
          end
          dac_d = (mode_n == SLOW_LIN) ? $unsigned(lerp_sample) : $unsigned(cur_n);
          if ((mode_n == SLOW_HOLD) || (mode_n == SLOW_LIN)) begin
            cnt_d = (cnt_q == speed_n) ? 3'd0 : cnt_q + 3'd1;
          end else begin
            cnt_d = 3'd0;
          end
        end
      end

      PAUSE: begin
        if (i_stop) begin
          state_d = IDLE;
          addr_d  = '0;
          cnt_d   = '0;
          prev_d  = '0;
          cur_d   = '0;
          dac_d   = '0;
        end else if (!i_pause && i_start) begin
          state_d = PLAY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mode_q  <= NORMAL;
      speed_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      dac_q   <= '0;
      done_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      dac_q   <= dac_d;
      done_q  <= done_d;
      lrck_q  <= i_daclrck;
    end
  end

  assign o_sram_addr = addr_q[ADDR_W-1:0];
  assign o_dac_data  = dac_q;
  assign o_player_en = (state_q == PLAY);
  assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_dsp.sv
`default_nettype none
// ============================================================================
// Module      : tb_aud_dsp
// Description : Self-checking bench for aud_dsp. A frame-level reference
//               model pushes the expected outputs each cycle; a monitor pops
//               and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_dsp;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int HALF   = 16;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              start   = 1'b0;
  logic              pause   = 1'b0;
  logic              stop    = 1'b0;
  logic [1:0]        mode    = 2'd0;
  logic [2:0]        speed   = 3'd0;
  logic              daclrck = 1'b0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [DATA_W-1:0] sram_data = '0;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] o_dac_data;
  logic              o_player_en;
  logic              o_done;

  logic [DATA_W-1:0] mem [0:127];

  typedef struct {
    logic [DATA_W-1:0] dac;
    logic              en;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  aud_dsp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_mode      (mode),
    .i_speed     (speed),
    .i_daclrck   (daclrck),
    .i_end_addr  (end_addr),
    .i_sram_data (sram_data),
    .o_sram_addr (o_sram_addr),
    .o_dac_data  (o_dac_data),
    .o_player_en (o_player_en),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  // SRAM with one cycle of read latency.
  always @(posedge clk) begin
    sram_data <= (o_sram_addr < 128) ? mem[o_sram_addr[6:0]] : 16'h0000;
  end

  initial begin : frame_gen
    forever begin
      repeat (HALF) @(negedge clk);
      daclrck = 1'b1;
      repeat (HALF) @(negedge clk);
      daclrck = 1'b0;
    end
  end

  function automatic longint recip(input int s);
    return (65536 + s - 1) / s;
  endfunction

  function automatic int floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return int'(q);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: playback described in terms of sample positions and
  // frames, reading sample values straight from the memory array.
  initial begin : model
    int   st    = 0;   // 0 idle, 1 playing, 2 paused
    int   pos   = 0;
    int   hc    = 0;
    int   prv   = 0;
    int   cr    = 0;
    int   rmode = 0;
    int   rs    = 1;
    int   outv  = 0;
    bit   lr    = 1'b0;
    bit   tk;
    bit   ld;
    bit   fin;
    bit   dn;
    exp_t e;
    forever begin
      @(posedge clk);
      dn = 1'b0;
      if (!rst_n) begin
        st = 0; pos = 0; hc = 0; prv = 0; cr = 0; rmode = 0; rs = 1; outv = 0; lr = 1'b0;
      end else begin
        tk = daclrck && !lr;
        lr = daclrck;
        if (st == 0) begin
          if (!stop && !pause && start) st = 1;
        end else if (stop) begin
          st = 0; pos = 0; hc = 0; prv = 0; cr = 0; outv = 0;
        end else if (st == 2) begin
          if (!pause && start) st = 1;
        end else if (pause) begin
          st = 2; outv = 0;
        end else if (tk) begin
          ld  = (rmode < 2) || (hc == 0);
          fin = 1'b0;
          if (ld && pos > int'(end_addr)) begin
            st = 0; dn = 1'b1; pos = 0; outv = 0; fin = 1'b1;
          end else if (ld) begin
            rmode = int'(mode);
            rs    = int'(speed) + 1;
            prv   = cr;
            cr    = int'($signed(mem[pos]));
            pos   = pos + ((rmode == 1) ? rs : 1);
          end
          if (!fin) begin
            if (rmode == 3)
              outv = prv + floor_div(longint'(cr - prv) * hc * recip(rs), 65536);
            else
              outv = cr;
            hc = (rmode >= 2) ? (hc + 1) % rs : 0;
          end
        end
      end
      e.dac  = 16'(outv);
      e.en   = (st == 1);
      e.done = dn;
      e.addr = 20'(pos);
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("dac_data",  32'(o_dac_data),  32'(e.dac));
        chk("player_en", 32'(o_player_en), 32'(e.en));
        chk("done",      32'(o_done),      32'(e.done));
        chk("sram_addr", 32'(o_sram_addr), 32'(e.addr));
      end
    end
  end

  task automatic frames(input int n);
    repeat (n) @(posedge daclrck);
  endtask

  task automatic mid_frame();
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; @(negedge clk); pause = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic set_cfg(input int m, input int s, input int e);
    mode     = 2'(m);
    speed    = 3'(s);
    end_addr = 20'(e);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 128; i++) mem[i] = 16'(100 * i);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin : stim
    for (int i = 0; i < 128; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    frames(10);                               // idle, no start

    // Normal playback of a ramp; speed must be ignored.
    fill_ramp();
    set_cfg(0, 5, 15);
    mid_frame(); pulse_start(); frames(19);

    // Fast, s = 3.
    set_cfg(1, 2, 10);
    mid_frame(); pulse_start(); frames(7);

    // Slow linear, s = 4, from a clean state.
    do_reset();
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[1] = 16'd400;
    set_cfg(3, 3, 2);
    mid_frame(); pulse_start(); frames(14);

    // Slow linear, s = 3, descending ramp exercises floor rounding.
    mem[0] = 16'd400;
    mem[1] = 16'd100;
    set_cfg(3, 2, 1);
    mid_frame(); pulse_start(); frames(8);

    // Slow hold, s = 2.
    fill_ramp();
    set_cfg(2, 1, 5);
    mid_frame(); pulse_start(); frames(14);

    // Control: pause/resume, stop+start together, pause on a tick.
    set_cfg(0, 0, 15);
    mid_frame(); pulse_start(); frames(3);
    mid_frame(); pulse_pause(); frames(2);
    mid_frame(); pulse_start(); frames(2);
    mid_frame();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    frames(2);
    mid_frame(); pulse_start(); frames(1);
    pause = 1'b1;                             // coincides with the tick
    @(negedge clk);
    pause = 1'b0;
    frames(2);
    mid_frame(); pulse_start(); frames(4);

    // Asynchronous reset in the middle of playback.
    mid_frame();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dac_data",  32'(o_dac_data),  32'd0);
    chk("rst_player_en", 32'(o_player_en), 32'd0);
    chk("rst_done",      32'(o_done),      32'd0);
    chk("rst_sram_addr", 32'(o_sram_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    frames(2);

    // Randomised runs with mid-play mode changes, pauses and restarts.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(4, 20));
      mid_frame(); pulse_start();
      for (int f = 0; f < 40; f++) begin
        frames(1);
        mid_frame();
        case ($urandom_range(0, 9))
          0: begin
            mode  = 2'($urandom_range(0, 3));
            speed = 3'($urandom_range(0, 7));
          end
          1:       pulse_pause();
          2, 3:    pulse_start();
          default: ;
        endcase
      end
      mid_frame(); pulse_stop();
    end

    frames(2);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
